// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RISC pipeline.
// Consumes the 72-bit EX/MEM bundle and performs loads/stores over a
// req/ack data-memory port with variable latency. While an access is
// outstanding the upstream pipeline is stalled. Misaligned accesses and
// accesses that see no ack within TIMEOUT wait cycles are reported on wb_err.
// The write-back bundle is registered and wb_valid is a one-cycle pulse.

module mem_access_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [71:0] ex_mem_in,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        wb_err
);

   // Last counter value before an access is abandoned.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t state;
   state_t next_state;

   // EX/MEM bundle fields
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;

   logic        mem_op;
   logic        bubble;
   logic        is_store;
   logic        misaligned;
   logic        timeout_hit;
   logic        stall_int;

   // Wait-cycle counter and the fields of the in-flight access
   logic [7:0]  counter;
   logic [7:0]  counter_n;
   logic [31:0] acc_alu;
   logic [31:0] acc_alu_n;
   logic [4:0]  acc_rd;
   logic [4:0]  acc_rd_n;
   logic        acc_reg_write;
   logic        acc_reg_write_n;

   // Next values of the registered outputs
   logic        dmem_req_n;
   logic        dmem_we_n;
   logic [31:0] dmem_addr_n;
   logic [31:0] dmem_wdata_n;
   logic        wb_valid_n;
   logic [31:0] wb_data_n;
   logic [4:0]  wb_rd_n;
   logic        wb_reg_write_n;
   logic        wb_err_n;

   assign alu_result = ex_mem_in[71:40];
   assign store_data = ex_mem_in[39:8];
   assign rd         = ex_mem_in[7:3];
   assign mem_read   = ex_mem_in[2];
   assign mem_write  = ex_mem_in[1];
   assign reg_write  = ex_mem_in[0];

   // A read+write bundle is treated as a load, so only a pure write stores.
   assign mem_op      = mem_read | mem_write;
   assign bubble      = (ex_mem_in[2:0] == 3'b000);
   assign is_store    = mem_write & ~mem_read;
   assign misaligned  = mem_op & (alu_result[1:0] != 2'b00);
   assign timeout_hit = (state == S_WAIT) && !dmem_ack && (counter == TIMEOUT_LAST);

   // Stall is forced low while reset is applied so upstream is never held by a dead access.
   assign stall = stall_int & ~rst;

   // FSM state register; reset aborts any outstanding access immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state, stall and next values of every registered output and access field.
   always_comb begin
      next_state      = state;
      stall_int       = 1'b0;
      counter_n       = counter;
      acc_alu_n       = acc_alu;
      acc_rd_n        = acc_rd;
      acc_reg_write_n = acc_reg_write;
      dmem_req_n      = dmem_req;
      dmem_we_n       = dmem_we;
      dmem_addr_n     = dmem_addr;
      dmem_wdata_n    = dmem_wdata;
      wb_valid_n      = 1'b0;
      wb_data_n       = wb_data;
      wb_rd_n         = wb_rd;
      wb_reg_write_n  = wb_reg_write;
      wb_err_n        = wb_err;

      unique case (state)
         S_IDLE: begin
            if (bubble) begin
               wb_valid_n = 1'b0;
            end else if (!mem_op) begin
               wb_valid_n     = 1'b1;
               wb_data_n      = alu_result;
               wb_rd_n        = rd;
               wb_err_n       = 1'b0;
               wb_reg_write_n = reg_write && (rd != 5'd0);
            end else if (misaligned) begin
               wb_valid_n     = 1'b1;
               wb_data_n      = alu_result;
               wb_rd_n        = rd;
               wb_err_n       = 1'b1;
               wb_reg_write_n = 1'b0;
            end else begin
               stall_int       = 1'b1;
               dmem_req_n      = 1'b1;
               dmem_we_n       = is_store;
               dmem_addr_n     = {alu_result[31:2], 2'b00};
               dmem_wdata_n    = store_data;
               counter_n       = 8'd0;
               acc_alu_n       = alu_result;
               acc_rd_n        = rd;
               acc_reg_write_n = reg_write;
               next_state      = S_WAIT;
            end
         end

         S_WAIT: begin
            if (dmem_ack) begin
               dmem_req_n = 1'b0;
               wb_valid_n = 1'b1;
               wb_rd_n    = acc_rd;
               wb_err_n   = 1'b0;
               if (dmem_we) begin
                  wb_data_n      = acc_alu;
                  wb_reg_write_n = 1'b0;
               end else begin
                  wb_data_n      = dmem_rdata;
                  wb_reg_write_n = acc_reg_write && (acc_rd != 5'd0);
               end
               counter_n  = 8'd0;
               next_state = S_IDLE;
            end else if (timeout_hit) begin
               dmem_req_n     = 1'b0;
               wb_valid_n     = 1'b1;
               wb_data_n      = acc_alu;
               wb_rd_n        = acc_rd;
               wb_err_n       = 1'b1;
               wb_reg_write_n = 1'b0;
               counter_n      = 8'd0;
               next_state     = S_IDLE;
            end else begin
               stall_int = 1'b1;
               counter_n = counter + 8'd1;
            end
         end

         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Memory-port registers and the captured fields of the access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter       <= 8'd0;
         acc_alu       <= 32'd0;
         acc_rd        <= 5'd0;
         acc_reg_write <= 1'b0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= 32'd0;
         dmem_wdata    <= 32'd0;
      end else begin
         counter       <= counter_n;
         acc_alu       <= acc_alu_n;
         acc_rd        <= acc_rd_n;
         acc_reg_write <= acc_reg_write_n;
         dmem_req      <= dmem_req_n;
         dmem_we       <= dmem_we_n;
         dmem_addr     <= dmem_addr_n;
         dmem_wdata    <= dmem_wdata_n;
      end
   end

   // Registered write-back bundle; wb_valid pulses for exactly one cycle per result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid     <= 1'b0;
         wb_data      <= 32'd0;
         wb_rd        <= 5'd0;
         wb_reg_write <= 1'b0;
         wb_err       <= 1'b0;
      end else begin
         wb_valid     <= wb_valid_n;
         wb_data      <= wb_data_n;
         wb_rd        <= wb_rd_n;
         wb_reg_write <= wb_reg_write_n;
         wb_err       <= wb_err_n;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for the MEM stage.
// The stimulus process pushes the expected write-back record for every
// instruction it issues; a monitor pops and compares whenever wb_valid is seen.

module tb_mem_access_stage;

   localparam int TIMEOUT = 4;

   logic        clk;
   logic        rst;
   logic [71:0] ex_mem_in;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_err;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        err;
   } wb_t;

   wb_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_mem_in    (ex_mem_in),
      .stall        (stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ack     (dmem_ack),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .wb_err       (wb_err)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [71:0] pack(input logic [31:0] alu, input logic [31:0] sd,
                                        input logic [4:0] rd, input logic mr,
                                        input logic mw, input logic rw);
      return {alu, sd, rd, mr, mw, rw};
   endfunction

   function automatic wb_t mk_wb(input logic [31:0] data, input logic [4:0] rd,
                                 input logic rw, input logic err);
      wb_t w;
      w.data      = data;
      w.rd        = rd;
      w.reg_write = rw;
      w.err       = err;
      return w;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write-back pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && wb_valid) begin
         if (exp_q.size() == 0) begin
            check_output("wb_unexpected", 32'd1, 32'd0);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            check_output("wb_data", wb_data, e.data);
            check_output("wb_rd", 32'(wb_rd), 32'(e.rd));
            check_output("wb_reg_write", 32'(wb_reg_write), 32'(e.reg_write));
            check_output("wb_err", 32'(wb_err), 32'(e.err));
         end
      end
   end

   // Single-cycle instruction (ALU op, misaligned access or bubble).
   task automatic apply_stimulus(input logic [71:0] instr, input logic push,
                                 input wb_t exp_wb);
      ex_mem_in = instr;
      if (push) exp_q.push_back(exp_wb);
      #1;
      check_output("stall_single", 32'(stall), 32'd0);
      tick();
      check_output("no_req_single", 32'(dmem_req), 32'd0);
      ex_mem_in = '0;
   endtask

   // Aligned access; ack arrives in the WAIT cycle numbered ack_at (0-based), if ever.
   task automatic run_access(input string name, input logic [71:0] instr, input int ack_at,
                             input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic exp_we, input logic [31:0] exp_wdata,
                             input int exp_stalls, input int exp_waits, input wb_t exp_wb);
      int  stalls;
      int  waits;
      bit  done;
      stalls = 0;
      waits  = 0;
      done   = 1'b0;
      ex_mem_in = instr;
      exp_q.push_back(exp_wb);
      #1;
      if (stall) stalls++;
      tick();
      check_output({name, "_req"}, 32'(dmem_req), 32'd1);
      check_output({name, "_addr"}, dmem_addr, exp_addr);
      check_output({name, "_we"}, 32'(dmem_we), 32'(exp_we));
      if (exp_we) check_output({name, "_wdata"}, dmem_wdata, exp_wdata);
      for (int w = 0; w < 20 && !done; w++) begin
         if (w == ack_at) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
         end
         #1;
         if (stall) stalls++;
         waits++;
         tick();
         dmem_ack = 1'b0;
         if (!dmem_req) done = 1'b1;
      end
      ex_mem_in = '0;
      check_output({name, "_done"}, 32'(done), 32'd1);
      check_output({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      check_output({name, "_waits"}, 32'(waits), 32'(exp_waits));
   endtask

   initial begin
      wb_t none;
      none = mk_wb(32'd0, 5'd0, 1'b0, 1'b0);
      rst        = 1'b1;
      ex_mem_in  = '0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_stall", 32'(stall), 32'd0);
      check_output("rst_req", 32'(dmem_req), 32'd0);
      check_output("rst_wb_valid", 32'(wb_valid), 32'd0);
      check_output("rst_wb_data", wb_data, 32'd0);
      rst = 1'b0;
      tick();

      $display("[TB] ALU ops");
      apply_stimulus(pack(32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b0, 1'b1), 1'b1,
                     mk_wb(32'h0000_1234, 5'd5, 1'b1, 1'b0));
      apply_stimulus(pack(32'h0000_0077, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1), 1'b1,
                     mk_wb(32'h0000_0077, 5'd0, 1'b0, 1'b0));
      apply_stimulus(72'd0, 1'b0, none);

      $display("[TB] load, ack in 4th wait cycle (coincides with timeout count)");
      run_access("ld100", pack(32'h0000_0100, 32'd0, 5'd7, 1'b1, 1'b0, 1'b1), 3,
                 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 32'd0, 4, 4,
                 mk_wb(32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0));

      $display("[TB] store, immediate ack");
      run_access("st204", pack(32'h0000_0204, 32'hCAFE_F00D, 5'd9, 1'b0, 1'b1, 1'b1), 0,
                 32'h1111_1111, 32'h0000_0204, 1'b1, 32'hCAFE_F00D, 1, 1,
                 mk_wb(32'h0000_0204, 5'd9, 1'b0, 1'b0));

      $display("[TB] load to x0 and read+write treated as load");
      run_access("ldx0", pack(32'h0000_0040, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1), 1,
                 32'h1234_5678, 32'h0000_0040, 1'b0, 32'd0, 2, 2,
                 mk_wb(32'h1234_5678, 5'd0, 1'b0, 1'b0));
      run_access("ldrw", pack(32'h0000_0300, 32'h5555_5555, 5'd3, 1'b1, 1'b1, 1'b1), 0,
                 32'hA5A5_0001, 32'h0000_0300, 1'b0, 32'd0, 1, 1,
                 mk_wb(32'hA5A5_0001, 5'd3, 1'b1, 1'b0));

      $display("[TB] misaligned accesses");
      apply_stimulus(pack(32'h0000_0103, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1), 1'b1,
                     mk_wb(32'h0000_0103, 5'd4, 1'b0, 1'b1));
      apply_stimulus(pack(32'h0000_0202, 32'hFFFF_0000, 5'd6, 1'b0, 1'b1, 1'b0), 1'b1,
                     mk_wb(32'h0000_0202, 5'd6, 1'b0, 1'b1));

      $display("[TB] load timeout");
      run_access("tmo", pack(32'h0000_0400, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1), 99,
                 32'd0, 32'h0000_0400, 1'b0, 32'd0, 4, 4,
                 mk_wb(32'h0000_0400, 5'd8, 1'b0, 1'b1));

      $display("[TB] ack while idle");
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
      tick();
      dmem_ack = 1'b0;
      check_output("idle_ack_req", 32'(dmem_req), 32'd0);
      tick();

      $display("[TB] reset during wait");
      ex_mem_in = pack(32'h0000_0500, 32'd0, 5'd2, 1'b1, 1'b0, 1'b1);
      tick();
      check_output("rw_req_before", 32'(dmem_req), 32'd1);
      tick();
      rst = 1'b1;
      #1;
      check_output("rw_req", 32'(dmem_req), 32'd0);
      check_output("rw_wb_valid", 32'(wb_valid), 32'd0);
      check_output("rw_stall", 32'(stall), 32'd0);
      ex_mem_in = '0;
      tick();
      rst = 1'b0;
      tick();
      apply_stimulus(pack(32'h0000_0ABC, 32'd0, 5'd11, 1'b0, 1'b0, 1'b1), 1'b1,
                     mk_wb(32'h0000_0ABC, 5'd11, 1'b1, 1'b0));
      tick();
      tick();

      check_output("wb_missing", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
